// File: rtl/qracc_pkg.sv
// Shared types, constants and helpers for the QRAcc macro interface and ADC readout.
package qracc_pkg;

  localparam int numCols    = 32;
  localparam int numAdcBits = 4;
  localparam int compCount  = (2**numAdcBits) - 1;
  localparam int numCfgBits = 8;
  localparam int accBits    = 16;

  typedef struct packed {
    logic [numCfgBits-1:0] n_input_bits_cfg;
    logic                  binary_cfg;
  } qracc_config_t;

  typedef struct packed {
    logic [numCols-1:0]           SA_OUT;
    logic [numCols*compCount-1:0] ADC_OUT;
  } from_analog_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } readout_state_t;

  // Popcount rather than leading-one search so comparator bubbles still decode sensibly.
  function automatic logic [numAdcBits-1:0] therm2bin(input logic [compCount-1:0] code);
    logic [numAdcBits-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < compCount; i++) begin
      cnt = cnt + {{(numAdcBits-1){1'b0}}, code[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/qracc_col_accum.sv
// One column of the bit-serial shift-and-accumulate: decode, offset, shift-add, clamp.
module qracc_col_accum
  import qracc_pkg::*;
#(
  parameter int ACC_BITS = accBits
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       step,
  input  logic                       neg,
  input  logic                       binary,
  input  logic [compCount-1:0]       code,
  output logic signed [ACC_BITS-1:0] acc,
  output logic                       sat
);

  localparam int W = ACC_BITS + numAdcBits + 2;
  localparam logic signed [W-1:0] ACC_MAX = {{(W-ACC_BITS+1){1'b0}}, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [W-1:0] ACC_MIN = {{(W-ACC_BITS+1){1'b1}}, {(ACC_BITS-1){1'b0}}};
  localparam logic signed [W-1:0] OFFSET  = W'(2**(numAdcBits-1));

  logic signed [W-1:0] val;
  logic signed [W-1:0] term;
  logic signed [W-1:0] sum;
  logic signed [ACC_BITS-1:0] acc_next;
  logic                overflow;

  always_comb begin
    val = $signed({{(W-numAdcBits){1'b0}}, therm2bin(code)});
    if (binary) begin
      val = val - OFFSET;
    end else begin
      val = val;
    end
    if (neg) begin
      term = -val;
    end else begin
      term = val;
    end
    sum = ($signed({{(W-ACC_BITS){acc[ACC_BITS-1]}}, acc}) <<< 1) + term;
    overflow = 1'b1;
    if (sum > ACC_MAX) begin
      acc_next = ACC_MAX[ACC_BITS-1:0];
    end else if (sum < ACC_MIN) begin
      acc_next = ACC_MIN[ACC_BITS-1:0];
    end else begin
      acc_next = sum[ACC_BITS-1:0];
      overflow = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (step) begin
      acc <= acc_next;
      sat <= sat | overflow;
    end else begin
      acc <= acc;
      sat <= sat;
    end
  end

endmodule

// File: rtl/qracc_adc_readout.sv
// ADC readout: sequences bit planes into per-column accumulators and hands results
// to the digital core; SA read data is captured on a separate, FSM-independent path.
module qracc_adc_readout
  import qracc_pkg::*;
#(
  parameter int ACC_BITS = accBits
) (
  input  logic                        clk,
  input  logic                        rst,
  input  qracc_config_t               cfg_i,
  input  from_analog_t                from_analog_i,
  input  logic                        start_i,
  input  logic                        adc_valid_i,
  input  logic                        sa_valid_i,
  output logic [numCols*ACC_BITS-1:0] acc_data_o,
  output logic [numCols-1:0]          acc_sat_o,
  output logic                        acc_valid_o,
  input  logic                        acc_ready_i,
  output logic [numCols-1:0]          sa_data_o,
  output logic                        sa_data_valid_o,
  output logic                        busy_o,
  output logic                        err_o
);

  readout_state_t state, state_next;
  logic [numCfgBits-1:0] n_q;
  logic [numCfgBits-1:0] k;
  logic                  binary_q;
  logic                  clear;
  logic                  step;
  logic                  neg;

  assign neg = (k == '0) && (n_q != numCfgBits'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          clear      = 1'b1;
          state_next = ACCUM;
        end else begin
          state_next = IDLE;
        end
      end
      ACCUM: begin
        if (adc_valid_i) begin
          step = 1'b1;
          if (k == n_q - numCfgBits'(1)) begin
            state_next = HOLD;
          end else begin
            state_next = ACCUM;
          end
        end else begin
          state_next = ACCUM;
        end
      end
      HOLD: begin
        if (acc_ready_i) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // An adc strobe outside ACCUM flags an error even when a start clears it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q         <= numCfgBits'(1);
      k           <= '0;
      binary_q    <= 1'b0;
      err_o       <= 1'b0;
      acc_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      if (clear) begin
        n_q      <= (cfg_i.n_input_bits_cfg == '0) ? numCfgBits'(1) : cfg_i.n_input_bits_cfg;
        k        <= '0;
        binary_q <= cfg_i.binary_cfg;
      end else if (step) begin
        k <= k + numCfgBits'(1);
      end
      if (adc_valid_i && (state != ACCUM)) begin
        err_o <= 1'b1;
      end else if (clear) begin
        err_o <= 1'b0;
      end
      acc_valid_o <= (state_next == HOLD);
      busy_o      <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_data_o       <= '0;
      sa_data_valid_o <= 1'b0;
    end else begin
      sa_data_o       <= sa_valid_i ? from_analog_i.SA_OUT : sa_data_o;
      sa_data_valid_o <= sa_valid_i;
    end
  end

  for (genvar c = 0; c < numCols; c++) begin : g_col
    qracc_col_accum #(.ACC_BITS(ACC_BITS)) u_col (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .step   (step),
      .neg    (neg),
      .binary (binary_q),
      .code   (from_analog_i.ADC_OUT[c*compCount +: compCount]),
      .acc    (acc_data_o[c*ACC_BITS +: ACC_BITS]),
      .sat    (acc_sat_o[c])
    );
  end

endmodule

// File: tb/tb_qracc_adc_readout.sv
// Scoreboard bench for qracc_adc_readout built with an 8-bit accumulator.
module tb_qracc_adc_readout;
  import qracc_pkg::*;

  localparam int AB = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  qracc_config_t          cfg_i;
  from_analog_t           from_analog_i;
  logic                   start_i, adc_valid_i, sa_valid_i, acc_ready_i;
  logic [numCols*AB-1:0]  acc_data_o;
  logic [numCols-1:0]     acc_sat_o, sa_data_o;
  logic                   acc_valid_o, sa_data_valid_o, busy_o, err_o;

  typedef struct packed {
    logic [numCols*AB-1:0] data;
    logic [numCols-1:0]    sat;
  } exp_t;

  exp_t sb[$];
  logic [numCols*compCount-1:0] planes [16];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  qracc_adc_readout #(.ACC_BITS(AB)) dut (
    .clk(clk), .rst(rst), .cfg_i(cfg_i), .from_analog_i(from_analog_i),
    .start_i(start_i), .adc_valid_i(adc_valid_i), .sa_valid_i(sa_valid_i),
    .acc_data_o(acc_data_o), .acc_sat_o(acc_sat_o), .acc_valid_o(acc_valid_o),
    .acc_ready_i(acc_ready_i), .sa_data_o(sa_data_o), .sa_data_valid_o(sa_data_valid_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  // Reference: popcount, optional offset, MSB-first signed recurrence with clamping.
  function automatic exp_t model(input int n, input bit bin);
    exp_t e;
    int nn;
    int v, a;
    bit s;
    logic [compCount-1:0] code;
    e = '0;
    nn = (n < 1) ? 1 : n;
    for (int c = 0; c < numCols; c++) begin
      a = 0;
      s = 1'b0;
      for (int k = 0; k < nn; k++) begin
        code = planes[k][c*compCount +: compCount];
        v = $countones(code);
        if (bin) v = v - 8;
        if (k == 0 && nn > 1) v = -v;
        a = 2 * a + v;
        if (a > 127) begin a = 127; s = 1'b1; end
        else if (a < -128) begin a = -128; s = 1'b1; end
      end
      e.data[c*AB +: AB] = AB'(a);
      e.sat[c] = s;
    end
    return e;
  endfunction

  task automatic random_planes();
    for (int k = 0; k < 16; k++)
      for (int c = 0; c < numCols; c++)
        planes[k][c*compCount +: compCount] = compCount'($urandom);
  endtask

  task automatic drive_op(input int n, input bit bin);
    int nn;
    nn = (n < 1) ? 1 : n;
    sb.push_back(model(n, bin));
    cfg_i.n_input_bits_cfg = numCfgBits'(n);
    cfg_i.binary_cfg = bin;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < nn; k++) begin
      from_analog_i.ADC_OUT = planes[k];
      adc_valid_i = 1'b1;
      @(negedge clk);
      adc_valid_i = 1'b0;
      if (k != nn - 1 && (k % 2) == 1) @(negedge clk);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (acc_valid_o === 1'b1) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic accept();
    acc_ready_i = 1'b1;
    @(negedge clk);
    acc_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({acc_data_o, acc_sat_o, acc_valid_o, sa_data_o, sa_data_valid_o, busy_o, err_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: data=%h sat=%h valid=%b sa=%h sav=%b busy=%b err=%b, want all 0",
               acc_data_o, acc_sat_o, acc_valid_o, sa_data_o, sa_data_valid_o, busy_o, err_o);
    end
  endtask

  task automatic test_single_plane();
    exp_t e;
    logic [numCols*AB-1:0] held;
    random_planes();
    planes[0][0 +: compCount] = 15'h007F;
    drive_op(1, 1'b0);
    tests_run++;
    if (acc_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_latency: acc_valid_o=%b want 1", acc_valid_o);
    end
    e = sb.pop_front();
    tests_run++;
    if (acc_data_o[0 +: AB] !== 8'd7 || acc_sat_o[0] !== 1'b0 || acc_data_o !== e.data || acc_sat_o !== e.sat) begin
      tests_failed++;
      $display("FAIL single_data: col0=%0d sat=%h data=%h want col0=7 data=%h sat=%h",
               $signed(acc_data_o[0 +: AB]), acc_sat_o, acc_data_o, e.data, e.sat);
    end
    held = acc_data_o;
    accept();
    tests_run++;
    if (acc_valid_o !== 1'b0 || busy_o !== 1'b0 || acc_data_o !== held) begin
      tests_failed++;
      $display("FAIL single_release: valid=%b busy=%b data=%h want 0 0 %h", acc_valid_o, busy_o, acc_data_o, held);
    end
  endtask

  task automatic test_msb_first();
    exp_t e;
    bit ok;
    random_planes();
    planes[0][3*compCount +: compCount] = 15'h7FFF;
    planes[1][3*compCount +: compCount] = 15'h0000;
    planes[2][3*compCount +: compCount] = 15'h0000;
    planes[3][3*compCount +: compCount] = 15'h7FFF;
    drive_op(4, 1'b0);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || acc_data_o[3*AB +: AB] !== 8'h97 || acc_data_o !== e.data || acc_sat_o !== e.sat) begin
      tests_failed++;
      $display("FAIL msb_first: valid=%b col3=%0d data=%h want col3=-105 data=%h sat=%h",
               ok, $signed(acc_data_o[3*AB +: AB]), acc_data_o, e.data, e.sat);
    end
    accept();
  endtask

  task automatic test_binary();
    exp_t e;
    bit ok;
    random_planes();
    planes[0][5*compCount +: compCount] = 15'h005F;
    planes[0][0 +: compCount] = 15'h0000;
    drive_op(1, 1'b1);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || acc_data_o[5*AB +: AB] !== 8'hFE || acc_data_o[0 +: AB] !== 8'hF8 || acc_data_o !== e.data) begin
      tests_failed++;
      $display("FAIL binary_offset: col5=%0d col0=%0d data=%h want -2 -8 data=%h",
               $signed(acc_data_o[5*AB +: AB]), $signed(acc_data_o[0 +: AB]), acc_data_o, e.data);
    end
    accept();
  endtask

  task automatic test_saturation();
    exp_t e;
    bit ok;
    planes[0] = {(numCols*compCount){1'b1}};
    for (int k = 1; k < 8; k++) planes[k] = '0;
    drive_op(8, 1'b0);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || acc_data_o !== {numCols{8'h80}} || acc_sat_o !== {numCols{1'b1}} || e.sat !== {numCols{1'b1}}) begin
      tests_failed++;
      $display("FAIL saturation: data=%h sat=%h want all 80 and sat all ones", acc_data_o, acc_sat_o);
    end
    accept();
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit ok;
    random_planes();
    drive_op(3, 1'b1);
    wait_valid(ok);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        from_analog_i.ADC_OUT = planes[5];
        adc_valid_i = 1'b1;
        start_i = 1'b1;
      end
      @(negedge clk);
      adc_valid_i = 1'b0;
      start_i = 1'b0;
      tests_run++;
      if (!ok || acc_valid_o !== 1'b1 || busy_o !== 1'b1 || acc_data_o !== e.data || acc_sat_o !== e.sat) begin
        tests_failed++;
        $display("FAIL backpressure_hold%0d: valid=%b busy=%b data=%h want 1 1 %h", i, acc_valid_o, busy_o, acc_data_o, e.data);
      end
    end
    tests_run++;
    if (err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_err: err_o=%b want 1", err_o);
    end
    accept();
  endtask

  task automatic test_err_rules();
    exp_t e;
    bit ok;
    random_planes();
    cfg_i.n_input_bits_cfg = 8'd0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    tests_run++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_clears_err: err=%b busy=%b want 0 1", err_o, busy_o);
    end
    repeat (2) @(negedge clk);
    from_analog_i.ADC_OUT = planes[0];
    adc_valid_i = 1'b1;
    @(negedge clk);
    adc_valid_i = 1'b0;
    sb.push_back(model(0, cfg_i.binary_cfg));
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || acc_data_o !== e.data) begin
      tests_failed++;
      $display("FAIL n_zero_as_one: valid=%b data=%h want %h", ok, acc_data_o, e.data);
    end
    accept();
    adc_valid_i = 1'b1;
    @(negedge clk);
    adc_valid_i = 1'b0;
    tests_run++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_adc_err: err=%b busy=%b want 1 0", err_o, busy_o);
    end
    random_planes();
    sb.push_back(model(2, 1'b0));
    cfg_i.n_input_bits_cfg = 8'd2;
    cfg_i.binary_cfg = 1'b0;
    from_analog_i.ADC_OUT = planes[7];
    start_i = 1'b1;
    adc_valid_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    adc_valid_i = 1'b0;
    tests_run++;
    if (err_o !== 1'b1 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_with_adc: err=%b busy=%b want 1 1", err_o, busy_o);
    end
    for (int k = 0; k < 2; k++) begin
      from_analog_i.ADC_OUT = planes[k];
      adc_valid_i = 1'b1;
      @(negedge clk);
      adc_valid_i = 1'b0;
    end
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || acc_data_o !== e.data || acc_sat_o !== e.sat) begin
      tests_failed++;
      $display("FAIL start_wins_result: valid=%b data=%h want %h", ok, acc_data_o, e.data);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit ok;
    random_planes();
    drive_op(3, 1'b0);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || acc_data_o !== e.data || acc_sat_o !== e.sat) begin
      tests_failed++;
      $display("FAIL b2b_first: valid=%b data=%h want %h", ok, acc_data_o, e.data);
    end
    start_i = 1'b1;
    accept();
    start_i = 1'b0;
    tests_run++;
    if (busy_o !== 1'b0 || acc_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_on_handshake: busy=%b valid=%b want 0 0", busy_o, acc_valid_o);
    end
    random_planes();
    drive_op(5, 1'b1);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || acc_data_o !== e.data || acc_sat_o !== e.sat) begin
      tests_failed++;
      $display("FAIL b2b_second: valid=%b data=%h sat=%h want %h %h", ok, acc_data_o, acc_sat_o, e.data, e.sat);
    end
    accept();
  endtask

  task automatic test_sa_path();
    logic [numCols-1:0] val;
    val = numCols'($urandom) | 32'h1;
    from_analog_i.SA_OUT = val;
    sa_valid_i = 1'b1;
    @(negedge clk);
    sa_valid_i = 1'b0;
    from_analog_i.SA_OUT = ~val;
    tests_run++;
    if (sa_data_valid_o !== 1'b1 || sa_data_o !== val) begin
      tests_failed++;
      $display("FAIL sa_capture: valid=%b data=%h want 1 %h", sa_data_valid_o, sa_data_o, val);
    end
    @(negedge clk);
    tests_run++;
    if (sa_data_valid_o !== 1'b0 || sa_data_o !== val) begin
      tests_failed++;
      $display("FAIL sa_pulse: valid=%b data=%h want 0 %h", sa_data_valid_o, sa_data_o, val);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit ok;
    random_planes();
    cfg_i.n_input_bits_cfg = 8'd4;
    cfg_i.binary_cfg = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      from_analog_i.ADC_OUT = planes[k];
      adc_valid_i = 1'b1;
      @(negedge clk);
      adc_valid_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({acc_data_o, acc_sat_o, acc_valid_o, busy_o, err_o, sa_data_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: data=%h sat=%h valid=%b busy=%b err=%b sa=%h want all 0",
               acc_data_o, acc_sat_o, acc_valid_o, busy_o, err_o, sa_data_o);
    end
    random_planes();
    drive_op(4, 1'b0);
    wait_valid(ok);
    e = sb.pop_front();
    tests_run++;
    if (!ok || acc_data_o !== e.data || acc_sat_o !== e.sat) begin
      tests_failed++;
      $display("FAIL reset_rerun: valid=%b data=%h want %h", ok, acc_data_o, e.data);
    end
    accept();
  endtask

  initial begin
    rst = 1'b1;
    cfg_i = '0;
    from_analog_i = '0;
    start_i = 1'b0;
    adc_valid_i = 1'b0;
    sa_valid_i = 1'b0;
    acc_ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_plane();
    test_msb_first();
    test_binary();
    test_saturation();
    test_backpressure();
    test_err_rules();
    test_back_to_back();
    test_sa_path();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/qracc_adc_readout.md
Name: qracc_adc_readout

Overview:
- Receive-side partner of the analog macro interface. Consumes `from_analog_t` (per-column thermometer ADC codes and SA_OUT) and converts thermometer codes to binary.
- Performs bit-serial shift-and-accumulate across input bit planes, then presents per-column MAC results to the digital core over a valid/ready handshake.
- Sits between the analog macro outputs and the output/quantization datapath. Timing comes from the macro sequencer's sample strobes.

Parameters:
- numCols, 32, columns per macro.
- numAdcBits, 4, ADC resolution.
- compCount, (2**numAdcBits)-1, comparators per column.
- numCfgBits, 8, config field width.
- accBits, 16, signed accumulator width per column.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_i  in  qracc_config_t  n_input_bits_cfg, binary_cfg; sampled on start_i.
- from_analog_i  in  from_analog_t  SA_OUT, ADC_OUT (column c uses bits [c*compCount +: compCount]).
- start_i  in  1  begin new accumulation.
- adc_valid_i  in  1  ADC_OUT holds a settled bit-plane result this cycle.
- sa_valid_i  in  1  SA_OUT holds settled read data this cycle.
- acc_data_o  out  numCols*accBits  column c at [c*accBits +: accBits], two's complement.
- acc_sat_o  out  numCols  per-column saturation flag.
- acc_valid_o  out  1  result valid.
- acc_ready_i  in  1  consumer accepts.
- sa_data_o  out  numCols  captured SA_OUT.
- sa_data_valid_o  out  1  one-cycle pulse.
- busy_o  out  1  FSM not in IDLE.
- err_o  out  1  sticky: adc_valid_i arrived outside ACCUM; cleared by start_i or rst.

Behaviour:
- Reset: all outputs 0; accumulators 0; FSM=IDLE. Reset mid-operation aborts immediately with no partial output.
- Decode: v = popcount(column thermometer code), range 0..compCount. Popcount tolerates bubbles.
  - binary_cfg=1: v' = v − 2^(numAdcBits−1), giving −8..7.
  - binary_cfg=0: v' = v.
- FSM IDLE:
  - start_i latches cfg into cfg_q, sets N = max(n_input_bits_cfg,1), plane counter k=0, clears acc/sat/err, and goes to ACCUM.
  - sa_valid_i and start_i are handled in every state; start_i is ignored outside IDLE.
- FSM ACCUM, on each adc_valid_i:
  - acc ← sat(2·acc + s·v'), with s=−1 when k==0 and N>1 (MSB-first two's-complement input), else s=+1.
  - k increments. When k==N−1 is consumed, go to HOLD.
  - Cycles without adc_valid_i hold state.
- Saturation:
  - Each step is computed at accBits+numAdcBits+2 bits, then clamped to [−2^(accBits−1), 2^(accBits−1)−1].
  - The per-column sat flag is sticky for the operation. Saturated value feeds later steps.
- FSM HOLD:
  - acc_valid_o=1 the cycle after the final adc_valid_i (latency 1).
  - acc_data_o and acc_sat_o are stable while valid && !ready.
  - On valid && ready, go to IDLE and drop valid the next cycle. acc_data_o retains its value.
- adc_valid_i in IDLE or HOLD: ignored, sets err_o.
- SA path, independent of FSM: sa_valid_i registers SA_OUT into sa_data_o and pulses sa_data_valid_o one cycle later.
- Simultaneous events:
  - start_i with the final acc_ready_i handshake: start is ignored, because the FSM is in HOLD that cycle.
  - adc_valid_i with start_i in IDLE: start wins and the sample is flagged as an error.

Decomposition:
- Add to qracc_pkg:
  - accBits constant.
  - readout_state_t enum {IDLE, ACCUM, HOLD}.
  - Function therm2bin (popcount over compCount bits).
- Sub-module qracc_col_accum, one instance per column via generate. It holds the decode offset, shift-add, saturation and sat flag.
- Top level holds FSM, plane counter, handshake, SA capture.

Test Plan:
- N=1, binary_cfg=0, col0 code 0x007F, one adc_valid → acc_valid next cycle, col0=7, sat=0.
- N=4, binary_cfg=0, col3 codes 0x7FFF,0,0,0x7FFF → col3=−105 (−15→−30→−60→−105).
- binary_cfg=1, N=1, col5 code 0x005F (bubbled, popcount 6) → col5=−2; code 0 → −8.
- accBits=8, N=8, all columns 0x7FFF then seven 0 planes → all cols −128, acc_sat_o all ones.
- Backpressure: acc_ready_i low 5 cycles after valid → data stable throughout; extra adc_valid_i and start_i during HOLD → err_o=1, no state change.
- rst asserted after 2 of 4 planes → outputs 0, IDLE. A new 4-plane run produces the correct result with no residue.
